imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
Boot-load controller for the instruction memory write port of the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word into instruction memory through WriteReg/WriteData/RegWrite and holds the CPU stalled until loading completes. After loading it releases the CPU and arbitrates the memory address port to the CPU program counter.

Parameters:
N_WORDS, 256, instruction memory depth in words; upper bound for load length
LEN_W, 16, width of load-length and word-count fields

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load of len words
len  input  LEN_W  number of 32-bit words to load, sampled when start=1
byte_valid  input  1  byte_data is valid
byte_data  input  8  incoming program byte
byte_ready  output  1  controller accepts a byte this cycle
pc  input  32  CPU program counter, byte address
imem_addr  output  32  word address to instruction memory read port
imem_WriteReg  output  32  word address for memory write
imem_WriteData  output  32  assembled instruction word
imem_RegWrite  output  1  memory write enable, one cycle per word
cpu_stall  output  1  1 = CPU must hold its PC and not commit
load_done  output  1  level; 1 while in RUN
load_err  output  1  level; 1 while in ERR
word_count  output  LEN_W  words written in the current load

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; byte_ready=0, imem_RegWrite=0, imem_WriteReg=0, imem_WriteData=0, imem_addr=0, cpu_stall=1, load_done=0, load_err=0, word_count=0, byte index=0.
- States: IDLE, LOAD, WRITE, RUN, ERR.
- IDLE: cpu_stall=1. If start=1, sample len and clear word_count and the byte index.
  - len==0 -> RUN.
  - len>N_WORDS -> ERR.
  - Otherwise -> LOAD.
- LOAD: byte_ready=1. A byte transfers only when byte_valid&&byte_ready at a rising edge. The byte lands in bits [8*i+7:8*i] of the word register, where i is the byte index 0..3. Transfer of byte 3 -> WRITE. byte_valid=0 simply waits; there is no timeout.
- WRITE: exactly one cycle.
  - byte_ready=0, imem_RegWrite=1, imem_WriteReg=word_count zero-extended, imem_WriteData=assembled word.
  - word_count increments at the end of the cycle.
  - If the new count equals len -> RUN; else -> LOAD.
- RUN: cpu_stall=0, load_done=1, byte_ready=0, imem_RegWrite=0.
  - imem_addr = {2'b00, pc[31:2]}, combinational passthrough with 0-cycle latency.
  - In every other state imem_addr=0.
- ERR: cpu_stall=1, load_err=1, byte_ready=0, imem_RegWrite=0. Leaves only on start (same decision as IDLE).
- start in LOAD or WRITE: ignored. Load continues.
- start in RUN: reload. Same decision as IDLE. cpu_stall rises the cycle after start.
- Per-word latency: 4 accepted bytes + 1 WRITE cycle. Minimum 5 cycles per word with byte_valid held high.
- Reset mid-load: immediate return to IDLE. Partial memory contents are left as written. word_count=0.
- word_count never exceeds len. No wrap-around is possible because len<=N_WORDS is enforced.

Optional Feature:
IMEM_BOOT_CHECKSUM_EN
- Defined: after the len-th WRITE the controller enters CHECK instead of RUN.
  - CHECK behaves like LOAD (byte_ready=1) and collects 4 more bytes as a little-endian checksum word. No memory write is issued for this word.
  - It compares the checksum to the mod-2^32 sum of all written words. Match -> RUN; mismatch -> ERR.
  - len==0 still goes straight to RUN.
- Undefined: no CHECK state, no accumulator. Last WRITE -> RUN directly.

Test Plan:
1. Reset, start with len=2, bytes B3 00 A2 00 13 05 10 00 with byte_valid high -> WriteReg=0/WriteData=0x00A200B3, then WriteReg=1/WriteData=0x00100513. Each write has RegWrite high for exactly one cycle. RUN reached 10 cycles after the first byte: cpu_stall=0, load_done=1, word_count=2.
2. In RUN drive pc=0x00000000 then 0x00000004 -> imem_addr=0 then 1 in the same cycle. With pc=0x8, resetn=0 mid-cycle -> cpu_stall=1 and imem_addr=0 immediately, without waiting for a clock edge.
3. start with len=300 (N_WORDS=256) -> ERR next cycle, load_err=1, byte_ready=0. A following start with len=1 -> LOAD, load_err=0.
4. start with len=1, bytes with byte_valid toggling 1,0,1,0 -> only valid cycles are accepted, and WriteData is assembled in correct order. start pulsed during LOAD is ignored, and word_count ends at 1.
5. In RUN, start with len=1 -> cpu_stall=1 the next cycle and the reload writes WriteReg=0. resetn=0 after 2 bytes -> IDLE, word_count=0, no RegWrite pulse.
6. With IMEM_BOOT_CHECKSUM_EN defined: words 0x00A200B3 and 0x00100513 followed by checksum 0x00B205C6 -> RUN. The same load with checksum 0x00000000 -> ERR, load_err=1, cpu_stall=1.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - boot loader filling instruction memory from a byte stream
//
// Assembles little-endian 32-bit words from a valid/ready byte stream and writes
// them into instruction memory, holding the CPU stalled until the load completes.
// Once loaded, the memory read address follows the CPU program counter.
//
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN
//   When defined, a 4-byte little-endian checksum follows the last word and must
//   equal the mod-2^32 sum of all written words, otherwise the load ends in ERR.
//
// Ports:
//   clock, resetn              clock (rising edge), asynchronous active-low reset
//   start, len                 load request pulse and number of words to load
//   byte_valid/byte_data       incoming program byte stream
//   byte_ready                 byte accepted when byte_valid && byte_ready
//   pc                         CPU program counter (byte address)
//   imem_addr                  word address to the memory read port (RUN only)
//   imem_WriteReg/WriteData    memory write address / data
//   imem_RegWrite              memory write enable, one cycle per word
//   cpu_stall                  CPU must hold its PC and not commit
//   load_done, load_err        status levels for RUN and ERR
//   word_count                 words written in the current load
module imem_boot_ctrl #(
  parameter int N_WORDS = 256,
  parameter int LEN_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic [31:0]      pc,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_WriteReg,
  output logic [31:0]      imem_WriteData,
  output logic             imem_RegWrite,
  output logic             cpu_stall,
  output logic             load_done,
  output logic             load_err,
  output logic [LEN_W-1:0] word_count
);

`ifdef IMEM_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN, S_ERR, S_CHECK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN, S_ERR} state_t;
`endif

  // One extra bit so the bound check cannot alias when N_WORDS == 2**LEN_W.
  localparam logic [LEN_W:0] LEN_MAX = (LEN_W+1)'(N_WORDS);

  state_t           state, state_nx, start_nx, last_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_inc;
  logic [1:0]       byte_idx;
  logic [31:0]      word_q;
  logic             byte_xfer;
  logic             start_take;
  logic             pc_unused;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0]      sum_q;
`endif

  // Word address drops the byte offset; the low pc bits are intentionally unused.
  assign pc_unused = ^pc[1:0];

  assign byte_xfer  = byte_valid && byte_ready;
  assign count_inc  = word_count + LEN_W'(1);
  // start only matters where a new load decision is allowed; LOAD/WRITE ignore it.
  assign start_take = start && (state == S_IDLE || state == S_RUN || state == S_ERR);

  // Decision shared by IDLE, RUN (reload) and ERR (retry).
  always_comb begin
    start_nx = S_LOAD;
    if (len == '0) begin
      start_nx = S_RUN;
    end else if ({1'b0, len} > LEN_MAX) begin
      start_nx = S_ERR;
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  assign last_nx = S_CHECK;
`else
  assign last_nx = S_RUN;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      len_q      <= '0;
      word_count <= '0;
      byte_idx   <= '0;
      word_q     <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state <= state_nx;
      if (start_take) begin
        len_q      <= len;
        word_count <= '0;
        byte_idx   <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_q      <= '0;
`endif
      end
      if (byte_xfer) begin
        word_q[8*byte_idx +: 8] <= byte_data;
        byte_idx                <= byte_idx + 2'd1;
      end
      if (state == S_WRITE) begin
        word_count <= count_inc;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_q      <= sum_q + word_q;
`endif
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) state_nx = start_nx;
      end
      S_LOAD: begin
        if (byte_xfer && byte_idx == 2'd3) state_nx = S_WRITE;
      end
      S_WRITE: begin
        state_nx = (count_inc == len_q) ? last_nx : S_LOAD;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CHECK: begin
        // The last checksum byte is still on the bus; compare the completed word.
        if (byte_xfer && byte_idx == 2'd3)
          state_nx = ({byte_data, word_q[23:0]} == sum_q) ? S_RUN : S_ERR;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready     = 1'b0;
    imem_RegWrite  = 1'b0;
    imem_WriteReg  = '0;
    imem_WriteData = '0;
    imem_addr      = '0;
    cpu_stall      = 1'b1;
    load_done      = 1'b0;
    load_err       = 1'b0;
    case (state)
      S_LOAD: byte_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CHECK: byte_ready = 1'b1;
`endif
      S_WRITE: begin
        imem_RegWrite  = 1'b1;
        imem_WriteReg  = 32'(word_count);
        imem_WriteData = word_q;
      end
      S_RUN: begin
        cpu_stall = 1'b0;
        load_done = 1'b1;
        imem_addr = {2'b00, pc[31:2]};
      end
      S_ERR: load_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - self-checking bench for imem_boot_ctrl
module tb_imem_boot_ctrl;
  localparam int N_WORDS = 256;
  localparam int LEN_W   = 16;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = '0;
  logic             byte_ready;
  logic [31:0]      pc = '0;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_WriteReg;
  logic [31:0]      imem_WriteData;
  logic             imem_RegWrite;
  logic             cpu_stall;
  logic             load_done;
  logic             load_err;
  logic [LEN_W-1:0] word_count;

  imem_boot_ctrl #(.N_WORDS(N_WORDS), .LEN_W(LEN_W)) dut (
    .clock(clock), .resetn(resetn), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .pc(pc), .imem_addr(imem_addr), .imem_WriteReg(imem_WriteReg),
    .imem_WriteData(imem_WriteData), .imem_RegWrite(imem_RegWrite),
    .cpu_stall(cpu_stall), .load_done(load_done), .load_err(load_err),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] act_q[$];

  // Observed writes, sampled mid-cycle; one entry per cycle RegWrite is high.
  always @(negedge clock) begin
    if (imem_RegWrite) act_q.push_back({imem_WriteReg, imem_WriteData});
  end

  typedef struct {
    logic [15:0] vlen;
    logic        exp_ready;
    logic        exp_err;
    logic        exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    logic [63:0] a, e;
    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual_addr=%h actual_data=%h expected=none", a[63:32], a[31:0]);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", a[63:32], e[63:32]);
        chk("write_data", a[31:0], e[31:0]);
      end
    end
  endtask

  task automatic pulse_start(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 40 && !ok; t++) begin
      ok = byte_ready;
      step();
    end
    byte_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout actual=no_ready expected=ready");
    end
    if (gap) begin
      byte_data = 8'hEE;
      step();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  // With the checksum feature the load is closed by the sum word.
  task automatic end_load(input logic [31:0] sum);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_word(sum, 1'b0);
`else
    if (sum == 32'h0) step();
`endif
  endtask

  task automatic wait_done();
    for (int t = 0; t < 50 && !load_done; t++) step();
    chk("load_done", {31'b0, load_done}, 32'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    vec_t vt[6];
    int c0;

    vt[0] = '{16'd0,     1'b0, 1'b0, 1'b1};
    vt[1] = '{16'd1,     1'b1, 1'b0, 1'b0};
    vt[2] = '{16'd256,   1'b1, 1'b0, 1'b0};
    vt[3] = '{16'd257,   1'b0, 1'b1, 1'b0};
    vt[4] = '{16'd300,   1'b0, 1'b1, 1'b0};
    vt[5] = '{16'hFFFF,  1'b0, 1'b1, 1'b0};

    // Reset state
    step();
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_regwrite", {31'b0, imem_RegWrite}, 32'd0);
    chk("rst_writereg", imem_WriteReg, 32'd0);
    chk("rst_writedata", imem_WriteData, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rst_done", {31'b0, load_done}, 32'd0);
    chk("rst_err", {31'b0, load_err}, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    resetn = 1'b1;
    step();

    // Two-word load with byte_valid held high
    pulse_start(16'd2);
    chk("t1_ready", {31'b0, byte_ready}, 32'd1);
    exp_q.push_back({32'd0, 32'h00A200B3});
    exp_q.push_back({32'd1, 32'h00100513});
    send_byte(8'hB3, 1'b0);
    c0 = cyc;
    send_byte(8'h00, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h00100513, 1'b0);
    end_load(32'h00B205C6);
    wait_done();
`ifndef IMEM_BOOT_CHECKSUM_EN
    chk("t1_latency", 32'(cyc - c0), 32'd9);
`endif
    chk("t1_stall", {31'b0, cpu_stall}, 32'd0);
    chk("t1_count", 32'(word_count), 32'd2);
    drain();

    // PC passthrough and asynchronous reset
    pc = 32'h0; #1;
    chk("t2_addr0", imem_addr, 32'd0);
    pc = 32'h4; #1;
    chk("t2_addr1", imem_addr, 32'd1);
    pc = 32'h8; #1;
    chk("t2_addr2", imem_addr, 32'd2);
    resetn = 1'b0; #1;
    chk("t2_async_stall", {31'b0, cpu_stall}, 32'd1);
    chk("t2_async_addr", imem_addr, 32'd0);
    step();
    resetn = 1'b1;
    step();

    // Length bound, then retry from ERR
    pulse_start(16'd300);
    chk("t3_err", {31'b0, load_err}, 32'd1);
    chk("t3_ready", {31'b0, byte_ready}, 32'd0);
    chk("t3_stall", {31'b0, cpu_stall}, 32'd1);
    pulse_start(16'd1);
    chk("t3_err_clr", {31'b0, load_err}, 32'd0);
    chk("t3_ready_load", {31'b0, byte_ready}, 32'd1);
    exp_q.push_back({32'd0, 32'h12345678});
    send_word(32'h12345678, 1'b0);
    end_load(32'h12345678);
    wait_done();
    drain();

    // Reload from RUN with gapped bytes and an ignored start mid-load
    pulse_start(16'd1);
    exp_q.push_back({32'd0, 32'h00100513});
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    pulse_start(16'd5);
    chk("t4_ignore_ready", {31'b0, byte_ready}, 32'd1);
    chk("t4_ignore_count", 32'(word_count), 32'd0);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    end_load(32'h00100513);
    wait_done();
    chk("t4_count", 32'(word_count), 32'd1);
    drain();

    // Reload stall timing, then reset in the middle of a load
    start = 1'b1;
    len = 16'd1;
    #1;
    chk("t5_stall_before", {31'b0, cpu_stall}, 32'd0);
    step();
    start = 1'b0;
    chk("t5_stall_after", {31'b0, cpu_stall}, 32'd1);
    exp_q.push_back({32'd0, 32'hCAFEF00D});
    send_word(32'hCAFEF00D, 1'b0);
    end_load(32'hCAFEF00D);
    wait_done();
    drain();
    pulse_start(16'd2);
    exp_q.push_back({32'd0, 32'h0BADBEEF});
    send_word(32'h0BADBEEF, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("t5_count_mid", 32'(word_count), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t5_rst_count", 32'(word_count), 32'd0);
    chk("t5_rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("t5_rst_done", {31'b0, load_done}, 32'd0);
    step();
    step();
    resetn = 1'b1;
    step();
    step();
    drain();

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum match and mismatch
    pulse_start(16'd2);
    exp_q.push_back({32'd0, 32'h00A200B3});
    exp_q.push_back({32'd1, 32'h00100513});
    send_word(32'h00A200B3, 1'b0);
    send_word(32'h00100513, 1'b0);
    send_word(32'h00B205C6, 1'b0);
    chk("t6_sum_ok", {31'b0, load_done}, 32'd1);
    drain();
    pulse_start(16'd2);
    exp_q.push_back({32'd0, 32'h00A200B3});
    exp_q.push_back({32'd1, 32'h00100513});
    send_word(32'h00A200B3, 1'b0);
    send_word(32'h00100513, 1'b0);
    send_word(32'h00000000, 1'b0);
    chk("t6_sum_err", {31'b0, load_err}, 32'd1);
    chk("t6_sum_stall", {31'b0, cpu_stall}, 32'd1);
    drain();
`endif

    // Start decision table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      pulse_start(vt[i].vlen);
      chk($sformatf("tbl%0d_ready", i), {31'b0, byte_ready}, {31'b0, vt[i].exp_ready});
      chk($sformatf("tbl%0d_err", i), {31'b0, load_err}, {31'b0, vt[i].exp_err});
      chk($sformatf("tbl%0d_done", i), {31'b0, load_done}, {31'b0, vt[i].exp_done});
      chk($sformatf("tbl%0d_stall", i), {31'b0, cpu_stall}, {31'b0, ~vt[i].exp_done});
    end

    step();
    drain();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
